// File: rtl/button_event_fifo.sv
// Four-button press-event queue: 2-flop sync, per-button debounce, pending bits, small event FIFO.
// Latency: a press reaches the head DEBOUNCE_CYCLES+4 edges after the raw input first samples high.
// Backpressure: a full FIFO holds events in pending bits; a press while already pending sets overflow.
// Optional macro BTN_AUTOREPEAT_EN: repeat press every REPEAT_CYCLES while a button stays held.
module button_event_fifo #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned REPEAT_CYCLES   = 7250000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       BTNU,
    input  logic       BTNR,
    input  logic       BTND,
    input  logic       BTNL,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [2:0] button,
    output logic [4:0] count,
    output logic       overflow
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned   PW       = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]    CNT_FULL = 5'(FIFO_DEPTH);

    generate
        if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20) ||
            FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_CYCLES < 2) begin : g_bad_param
            $error("button_event_fifo: parameter out of range");
        end
    endgenerate

    // Bit order everywhere: 0=U, 1=R, 2=D, 3=L (also the push priority order).
    logic [3:0]    btn_raw;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    deb_q;
    logic [3:0]    deb_d;
    logic [3:0]    toggle;
    logic [3:0]    press_q;
    logic [3:0]    press_d;
    logic [3:0]    pend_q;
    logic [3:0]    pend_d;
    logic [3:0]    grant;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];

    logic [2:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [4:0]    count_q;
    logic [4:0]    count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          pop;
    logic          push;
    logic [2:0]    push_code;

    assign btn_raw = {BTNL, BTND, BTNR, BTNU};

    always_comb begin
        toggle = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    toggle[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        deb_d = deb_q ^ toggle;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned   RW       = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q [4];
    logic [RW-1:0] rep_d [4];
    logic [3:0]    rep_fire;

    // Timer runs only while the debounced level is, and stays, high.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < 4; i++) begin
            rep_d[i] = '0;
            if (deb_q[i] && !toggle[i]) begin
                if (rep_q[i] == REP_LAST) begin
                    rep_fire[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + 1'b1;
                end
            end
        end
        press_d = (toggle & ~deb_q) | rep_fire;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                rep_q[i] <= '0;
            end else begin
                rep_q[i] <= rep_d[i];
            end
        end
    end
`else
    assign press_d = toggle & ~deb_q;
`endif

    always_comb begin
        pop       = rd_en && (count_q != 5'd0);
        grant     = '0;
        push_code = 3'd0;
        if (count_q != CNT_FULL || pop) begin
            if (pend_q[0]) begin
                grant     = 4'b0001;
                push_code = 3'd1;
            end else if (pend_q[1]) begin
                grant     = 4'b0010;
                push_code = 3'd2;
            end else if (pend_q[2]) begin
                grant     = 4'b0100;
                push_code = 3'd3;
            end else if (pend_q[3]) begin
                grant     = 4'b1000;
                push_code = 3'd4;
            end
        end
        push = |grant;

        // A press on an already-pending button is dropped and flagged.
        pend_d   = (press_q & ~pend_q) | (pend_q & ~grant);
        ovf_d    = (|(press_q & pend_q)) | (ovf_q & ~clr_ovf);
        count_d  = count_q + 5'(push) - 5'(pop);
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            deb_q    <= '0;
            press_q  <= '0;
            pend_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= 5'd0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            press_q  <= press_d;
            pend_q   <= pend_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    assign button   = (count_q != 5'd0) ? mem_q[rd_ptr_q] : 3'd0;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_button_event_fifo.sv
// Directed and randomized bench for button_event_fifo, compared every cycle against a queue-based event model.
module tb_button_event_fifo;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;
    localparam int REP   = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       BTNU;
    logic       BTNR;
    logic       BTND;
    logic       BTNL;
    logic       rd_en;
    logic       clr_ovf;
    logic [2:0] button;
    logic [4:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    button_event_fifo #(
        .DEBOUNCE_CYCLES(DEB),
        .FIFO_DEPTH     (DEPTH),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .BTNU    (BTNU),
        .BTNR    (BTNR),
        .BTND    (BTND),
        .BTNL    (BTNL),
        .rd_en   (rd_en),
        .clr_ovf (clr_ovf),
        .button  (button),
        .count   (count),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Reference model: event queue plus per-button debounce bookkeeping.
    int       q[$];
    bit [3:0] m_d1;
    bit [3:0] m_d2;
    bit [3:0] m_deb;
    bit [3:0] m_pend;
    bit [3:0] m_press;
    int       m_streak[4];
    bit       m_ovf;
`ifdef BTN_AUTOREPEAT_EN
    int       m_held[4];
`endif

    int       exp_heads[6];
    bit [3:0] r_lvl;
    int       r_hold[4];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_d1    = '0;
        m_d2    = '0;
        m_deb   = '0;
        m_pend  = '0;
        m_press = '0;
        m_ovf   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_streak[i] = 0;
`ifdef BTN_AUTOREPEAT_EN
            m_held[i] = 0;
`endif
        end
    endtask

    task automatic model_edge(input bit [3:0] btn, input bit rd, input bit clr, input bit rst);
        bit       do_pop;
        int       g;
        bit       ovf_new;
        bit [3:0] rise;
        bit [3:0] rep;
        bit       was_high;
        bit       flipped;
        if (rst) begin
            model_reset();
            return;
        end
        do_pop = rd && (q.size() > 0);
        g = -1;
        if (q.size() < DEPTH || do_pop) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend[i] && g < 0) g = i;
            end
        end
        ovf_new = |(m_press & m_pend);
        for (int i = 0; i < 4; i++) begin
            if (m_pend[i]) m_pend[i] = (i != g);
            else           m_pend[i] = m_press[i];
        end
        if (do_pop) void'(q.pop_front());
        if (g >= 0) q.push_back(g + 1);
        m_ovf = ovf_new || (m_ovf && !clr);

        rise = '0;
        rep  = '0;
        for (int i = 0; i < 4; i++) begin
            was_high = m_deb[i];
            flipped  = 1'b0;
            if (m_d2[i] != m_deb[i]) begin
                m_streak[i]++;
                if (m_streak[i] == DEB) begin
                    m_deb[i]    = ~m_deb[i];
                    m_streak[i] = 0;
                    flipped     = 1'b1;
                    if (m_deb[i]) begin
                        rise[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        m_held[i] = 0;
`endif
                    end
                end
            end else begin
                m_streak[i] = 0;
            end
`ifdef BTN_AUTOREPEAT_EN
            if (was_high && !flipped) begin
                m_held[i]++;
                if (m_held[i] % REP == 0) rep[i] = 1'b1;
            end
`else
            if (was_high && flipped) rep[i] = 1'b0;
`endif
        end
        m_press = rise | rep;
        m_d2    = m_d1;
        m_d1    = btn;
    endtask

    task automatic step(input bit [3:0] btn, input bit rd, input bit clr, input bit rst);
        {BTNL, BTND, BTNR, BTNU} = btn;
        rd_en   = rd;
        clr_ovf = clr;
        reset   = rst;
        @(posedge clock);
        model_edge(btn, rd, clr, rst);
        #1;
        chk("model_button",   8'(button),   (q.size() > 0) ? 8'(q[0]) : 8'd0);
        chk("model_count",    8'(count),    8'(q.size()));
        chk("model_overflow", 8'(overflow), 8'(m_ovf));
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        exp_heads = '{1, 2, 3, 4, 1, 2};

        do_reset();
        chk("reset_count",    8'(count),    8'd0);
        chk("reset_button",   8'(button),   8'd0);
        chk("reset_overflow", 8'(overflow), 8'd0);

        // Single right press held for 20 cycles.
        for (int k = 1; k <= 20; k++) begin
            step(4'b0010, 1'b0, 1'b0, 1'b0);
            if (k == 7) chk("r_before_edge8", 8'(button), 8'd0);
            if (k == 8) begin
                chk("r_button_edge8", 8'(button), 8'd2);
                chk("r_count_edge8",  8'(count),  8'd1);
            end
        end
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        chk("r_pop_button", 8'(button), 8'd0);
        chk("r_pop_count",  8'(count),  8'd0);
        repeat (10) step(4'b0000, 1'b0, 1'b0, 1'b0);

        // Short glitch on up.
        do_reset();
        repeat (3)  step(4'b0001, 1'b0, 1'b0, 1'b0);
        repeat (12) step(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("glitch_count",  8'(count),  8'd0);
        chk("glitch_button", 8'(button), 8'd0);

        // Up and left together.
        do_reset();
        repeat (7) step(4'b1001, 1'b0, 1'b0, 1'b0);
        chk("ul_count_edge7", 8'(count), 8'd0);
        step(4'b1001, 1'b0, 1'b0, 1'b0);
        chk("ul_first_button", 8'(button), 8'd1);
        chk("ul_first_count",  8'(count),  8'd1);
        step(4'b1001, 1'b0, 1'b0, 1'b0);
        chk("ul_second_count", 8'(count), 8'd2);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        chk("ul_pop1_button", 8'(button), 8'd4);
        chk("ul_pop1_count",  8'(count),  8'd1);
        step(4'b1001, 1'b1, 1'b0, 1'b0);
        chk("ul_pop2_count", 8'(count), 8'd0);

        // Fill, hold pending while full, then overflow on a re-press.
        do_reset();
        repeat (12) step(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("full_count", 8'(count),  8'd4);
        chk("full_head",  8'(button), 8'd1);
        repeat (8) step(4'b1100, 1'b0, 1'b0, 1'b0);
        repeat (8) step(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("full_held_count", 8'(count),    8'd4);
        chk("no_ovf_yet",      8'(overflow), 8'd0);
        repeat (8) step(4'b1110, 1'b0, 1'b0, 1'b0);
        repeat (8) step(4'b1111, 1'b0, 1'b0, 1'b0);
        chk("ovf_set",   8'(overflow), 8'd1);
        chk("ovf_count", 8'(count),    8'd4);
`ifndef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 6; k++) begin
            chk("drain_head", 8'(button), 8'(exp_heads[k]));
            step(4'b1111, 1'b1, 1'b0, 1'b0);
            if (k == 0) chk("full_pop_push_count", 8'(count), 8'd4);
        end
        chk("drain_empty", 8'(count), 8'd0);
        step(4'b1111, 1'b0, 1'b1, 1'b0);
        chk("ovf_clear", 8'(overflow), 8'd0);
`else
        repeat (12) step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b1, 1'b0);
`endif

        // Reset mid-operation with down held.
        do_reset();
        repeat (10) step(4'b0111, 1'b0, 1'b0, 1'b0);
        chk("pre_reset_count", 8'(count), 8'd3);
        step(4'b0100, 1'b0, 1'b0, 1'b1);
        chk("mid_reset_count",  8'(count),  8'd0);
        chk("mid_reset_button", 8'(button), 8'd0);
        repeat (7) step(4'b0100, 1'b0, 1'b0, 1'b0);
        chk("post_reset_edge7", 8'(count), 8'd0);
        step(4'b0100, 1'b0, 1'b0, 1'b0);
        chk("post_reset_button", 8'(button), 8'd3);
        chk("post_reset_count",  8'(count),  8'd1);
        repeat (16) step(4'b0100, 1'b0, 1'b0, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
        chk("repeat_count", 8'(count), 8'd2);
`else
        chk("no_repeat_count", 8'(count), 8'd1);
`endif

        // Randomized button activity, pops, clears and occasional resets.
        do_reset();
        r_lvl = '0;
        for (int i = 0; i < 4; i++) r_hold[i] = int'($urandom_range(0, 10));
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (r_hold[i] == 0) begin
                    r_lvl[i]  = ~r_lvl[i];
                    r_hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                            : int'($urandom_range(5, 24));
                end else begin
                    r_hold[i]--;
                end
            end
            step(r_lvl,
                 (n < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
